// File: rtl/axi_lite_cnn_ctrl_regs.sv
// AXI4-Lite control/status register bank for the CNN accelerator core.
// Optional IRQ support is compiled in with `define CNN_CTRL_IRQ_EN.
module axi_lite_cnn_ctrl_regs #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                acc_start,
  output logic [DATA_W-1:0]   acc_ifm_addr,
  output logic [DATA_W-1:0]   acc_wgt_addr,
  output logic [DATA_W-1:0]   acc_ofm_addr,
  output logic [DATA_W-1:0]   acc_layer_cfg,
  input  logic                acc_busy,
  input  logic                acc_done,
  output logic                irq
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  ready_en_q;
  logic [2:0]            awaddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [1:0]            bresp_q;
  logic [DATA_W-1:0]     rdata_q, rd_data;
  logic [DATA_W-1:0]     ifm_q, wgt_q, ofm_q, cfg_q;
  logic                  done_q, start_q;
  logic                  irqen_rd, irqstat_rd;

  logic                  aw_hs, w_hs, ar_hs, wr_en, wr_ro, start_wr;
  logic [2:0]            wr_idx;
  logic [DATA_W-1:0]     wr_data, wr_mask;
  logic [DATA_W/8-1:0]   wr_strb;
  logic                  unused_addr;

  assign unused_addr = ^{s_awaddr, s_araddr};

  assign s_awready = ready_en_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_W));
  assign s_wready  = ready_en_q & ((wstate_q == W_IDLE) | (wstate_q == W_HAVE_AW));
  assign s_bvalid  = (wstate_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = ready_en_q & (rstate_q == R_IDLE);
  assign s_rvalid  = (rstate_q == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = 2'b00;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // The write is committed on whichever edge completes the second of AW/W,
  // mixing the freshly presented channel with the one latched earlier.
  always_comb begin
    wstate_d = wstate_q;
    wr_en    = 1'b0;
    wr_idx   = s_awaddr[4:2];
    wr_data  = s_wdata;
    wr_strb  = s_wstrb;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        wr_idx = awaddr_q;
        if (w_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (aw_hs) begin
          wr_en    = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_DATA;
      R_DATA:  if (s_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  assign wr_mask  = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign wr_ro    = (wr_idx == 3'd1) || (wr_idx == 3'd7);
  assign start_wr = wr_en && (wr_idx == 3'd0) && wr_strb[0] && wr_data[0];

  always_comb begin
    rd_data = '0;
    case (s_araddr[4:2])
      3'd0: rd_data = {{(DATA_W-2){1'b0}}, irqen_rd, 1'b0};
      3'd1: rd_data = {{(DATA_W-2){1'b0}}, done_q, acc_busy};
      3'd2: rd_data = ifm_q;
      3'd3: rd_data = wgt_q;
      3'd4: rd_data = ofm_q;
      3'd5: rd_data = cfg_q;
      3'd6: rd_data = {{(DATA_W-1){1'b0}}, irqstat_rd};
      3'd7: rd_data = VERSION;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      ready_en_q <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      ifm_q      <= '0;
      wgt_q      <= '0;
      ofm_q      <= '0;
      cfg_q      <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      ready_en_q <= 1'b1;
      start_q    <= start_wr;
      if (aw_hs) awaddr_q <= s_awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (wr_en) begin
        bresp_q <= wr_ro ? 2'b10 : 2'b00;
        case (wr_idx)
          3'd2: ifm_q <= (ifm_q & ~wr_mask) | (wr_data & wr_mask);
          3'd3: wgt_q <= (wgt_q & ~wr_mask) | (wr_data & wr_mask);
          3'd4: ofm_q <= (ofm_q & ~wr_mask) | (wr_data & wr_mask);
          3'd5: cfg_q <= (cfg_q & ~wr_mask) | (wr_data & wr_mask);
          default: ;
        endcase
      end
      if (start_wr)      done_q <= 1'b0;
      else if (acc_done) done_q <= 1'b1;
      if (ar_hs) rdata_q <= rd_data;
    end
  end

`ifdef CNN_CTRL_IRQ_EN
  logic irqen_q, irqstat_q, irq_q, irq_clr;

  assign irq_clr    = wr_en && (wr_idx == 3'd6) && wr_strb[0] && wr_data[0];
  assign irqen_rd   = irqen_q;
  assign irqstat_rd = irqstat_q;
  assign irq        = irq_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      irqen_q   <= 1'b0;
      irqstat_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en && (wr_idx == 3'd0) && wr_strb[0]) irqen_q <= wr_data[1];
      if (acc_done)     irqstat_q <= 1'b1;
      else if (irq_clr) irqstat_q <= 1'b0;
      irq_q <= irqstat_q & irqen_q;
    end
  end
`else
  assign irqen_rd   = 1'b0;
  assign irqstat_rd = 1'b0;
  assign irq        = 1'b0;
`endif

  assign acc_start     = start_q;
  assign acc_ifm_addr  = ifm_q;
  assign acc_wgt_addr  = wgt_q;
  assign acc_ofm_addr  = ofm_q;
  assign acc_layer_cfg = cfg_q;

endmodule

// File: doc/axi_lite_cnn_ctrl_regs.md
# axi_lite_cnn_ctrl_regs

AXI4-Lite slave register bank that terminates the master-side AXI traffic driven into `chip` and converts it into the control/status interface of the CNN accelerator core. It sits directly downstream of the AXI interconnect/passthrough stage and upstream of the accelerator datapath. It holds buffer base addresses and the layer configuration, issues a one-cycle start pulse and captures completion status.

## Interface
Parameters:
- `ADDR_W`, 5: AXI address width; `addr[4:2]` selects one of 8 word registers; `addr[1:0]` is ignored.
- `DATA_W`, 32: AXI data width; fixed at 32, other values unsupported.
- `VERSION`, 32'h0001_0000: value returned by the VERSION register.

Ports:
- `aclk` in 1: sole clock, all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_awaddr` in ADDR_W, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in ADDR_W, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `acc_start` out 1: one-cycle start pulse to the accelerator.
- `acc_ifm_addr`, `acc_wgt_addr`, `acc_ofm_addr`, `acc_layer_cfg` out 32 each: register contents.
- `acc_busy` in 1: level, accelerator running.
- `acc_done` in 1: one-cycle completion pulse.
- `irq` out 1: level interrupt (see Configuration).

## Operation
Register map, byte offsets:
- 0x00 CTRL: bit0 START, write-1 generates `acc_start` and reads 0; bit1 IRQ_EN RW.
- 0x04 STATUS RO: bit0 = `acc_busy`; bit1 DONE, sticky, set by `acc_done`, cleared by a START write.
- 0x08 IFM_ADDR, 0x0C WGT_ADDR, 0x10 OFM_ADDR, 0x14 LAYER_CFG: RW, byte-masked by `s_wstrb`.
- 0x18 IRQ_STAT: bit0, set by `acc_done`, write-1-to-clear.
- 0x1C VERSION RO.

Write path (FSM states IDLE, HAVE_AW, HAVE_W, RESP):
- AW and W are accepted independently and latched. `s_awready` is high only in IDLE/HAVE_W; `s_wready` is high only in IDLE/HAVE_AW.
- When both are latched, the register write is performed and the FSM enters RESP with `s_bvalid` = 1.
- The FSM stays in RESP until `s_bready` is seen, then returns to IDLE.
- A write to a RO offset (0x04, 0x1C) returns SLVERR (2'b10) with no effect; all other writes return OKAY.
- START requires `s_wstrb[0]` = 1.

Read path (states IDLE, RDATA):
- `s_arready` = 1 in IDLE. The handshake registers `s_rdata` and `s_rresp` = OKAY, and the FSM enters RDATA.
- In RDATA, `s_rdata` and `s_rvalid` are held stable until `s_rready`.

Simultaneous events:
- A read and a write in the same cycle proceed independently; the read returns the pre-write value.
- `acc_done` and a START write in the same cycle: START wins, so DONE ends at 0.
- `acc_done` and an IRQ_STAT W1C in the same cycle: set wins.

## Timing
- Reset: all registers 0; all `*ready`/`*valid` outputs, `acc_start` and `irq` are 0. Ready outputs go high the cycle after `areset` deasserts.
- Reset mid-transaction aborts it; no response is issued.
- Write with AW and W on edge N: register updated and `s_bvalid` = 1 after edge N+1. `acc_start` pulses for exactly the cycle after edge N+1.
- Read with AR on edge N: `s_rvalid` = 1 after edge N+1.
- Throughput: one write per 2 cycles with `s_bready` tied high; one read per 2 cycles.
- DONE and IRQ_STAT update one cycle after `acc_done`.

## Configuration
- `CNN_CTRL_IRQ_EN` defined: `irq` = IRQ_STAT[0] & CTRL[1], registered, so it rises one cycle after the status bit. IRQ_STAT behaves as specified above.
- `CNN_CTRL_IRQ_EN` undefined: `irq` is tied 0. IRQ_STAT reads 0, writes are accepted with OKAY and have no effect, and CTRL[1] reads 0.

## Test plan
- Reset then read all 8 offsets -> 0 everywhere except 0x1C = 32'h0001_0000; all responses OKAY.
- Write 0x08 = 32'hDEAD_BEEF with AW 3 cycles before W, then write `wstrb` = 4'b0010 data 32'h0000_5500 -> readback 32'hDEAD_55EF and `acc_ifm_addr` matches.
- Write 0x00 = 32'h3 -> `acc_start` high for exactly one cycle. Pulse `acc_done` -> STATUS = 32'h2, and `irq` = 1 if IRQ_EN is compiled in. W1C 0x18 -> `irq` = 0.
- Write 0x1C -> `s_bresp` = 2'b10 and VERSION is unchanged. Hold `s_bready` low for 5 cycles -> `s_bvalid` stays high and `s_awready` stays low throughout.
- Issue a read of 0x14 in the same cycle as a write of 0x14 = 32'h7 -> read returns the old value 0; the following read returns 7.
- Assert `areset` while `s_rvalid` is pending -> `s_rvalid` = 0 the next cycle and all registers = 0.
